// File: rtl/ffra_mac_pipe_if.sv
// ffra_mac_pipe_if: operand/result valid-ready bundle for ffra_mac_pipe
interface ffra_mac_pipe_if #(
  parameter int A_W = 8,
  parameter int B_W = 8,
  parameter int O_W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [O_W-1:0] ci;
  logic [1:0]     mode;
  logic           sgn;
  logic           out_valid;
  logic           out_ready;
  logic [O_W-1:0] o;
  logic           ovf;
  modport slave (
    input  in_valid, a, b, ci, mode, sgn, out_ready,
    output in_ready, out_valid, o, ovf
  );
  modport master (
    output in_valid, a, b, ci, mode, sgn, out_ready,
    input  in_ready, out_valid, o, ovf
  );
endinterface

// File: rtl/ffra_mac_pipe.sv
// ffra_mac_pipe: two-stage multiply-add/accumulate with saturate-or-wrap and valid/ready flow control
module ffra_mac_pipe #(
  parameter int A_W = 8,
  parameter int B_W = 8,
  parameter int O_W = 16,
  parameter bit SAT = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  ffra_mac_pipe_if.slave bus
);
  localparam int P_W = A_W + B_W;
  localparam int W   = O_W + 2;
  localparam logic [O_W-1:0] S_MAX = {1'b0, {(O_W-1){1'b1}}};
  localparam logic [O_W-1:0] S_MIN = {1'b1, {(O_W-1){1'b0}}};
  logic           s1_v_q, sgn_q, s2_v_q, ovf_q;
  logic [P_W-1:0] p_q;
  logic [O_W-1:0] ci_q, o_q, acc_q;
  logic [1:0]     mode_q;
  logic           s2_ld, s1_mv, hi_ovf, lo_ovf, ovf_d;
  logic [P_W-1:0] a_x, b_x, p_d;
  logic [W-1:0]   p_x, ci_x, acc_x, r;
  logic [O_W-1:0] o_d;
  assign s2_ld         = !s2_v_q || bus.out_ready;
  assign s1_mv         = s1_v_q && s2_ld;
  assign bus.in_ready  = !s1_v_q || s2_ld;
  assign bus.out_valid = s2_v_q;
  assign bus.o         = o_q;
  assign bus.ovf       = ovf_q;
  // product at full A_W+B_W width; low bits of an extended multiply are exact for either signedness
  always_comb begin
    a_x = bus.sgn ? P_W'($signed(bus.a)) : P_W'(bus.a);
    b_x = bus.sgn ? P_W'($signed(bus.b)) : P_W'(bus.b);
    p_d = a_x * b_x;
  end
  // stage-2 arithmetic at O_W+2 bits, then range check and clamp/wrap back to O_W
  always_comb begin
    p_x    = sgn_q ? W'($signed(p_q))   : W'(p_q);
    ci_x   = sgn_q ? W'($signed(ci_q))  : W'(ci_q);
    acc_x  = sgn_q ? W'($signed(acc_q)) : W'(acc_q);
    r      = mode_q == 2'b01 ? p_x - ci_x : mode_q == 2'b10 ? acc_x + p_x : p_x + ci_x;
    lo_ovf = sgn_q ? r[W-1] && !(&r[W-1:O_W-1]) : r[W-1];
    hi_ovf = sgn_q ? !r[W-1] && |r[W-1:O_W-1] : !r[W-1] && |r[W-2:O_W];
    ovf_d  = lo_ovf || hi_ovf;
    o_d    = SAT && hi_ovf ? (sgn_q ? S_MAX : '1) :
             SAT && lo_ovf ? (sgn_q ? S_MIN : '0) : r[O_W-1:0];
  end
  // stage 1: take a new beat whenever the stage is empty or draining into stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      p_q    <= '0;
      ci_q   <= '0;
      mode_q <= '0;
      sgn_q  <= 1'b0;
    end else if (bus.in_ready) begin
      s1_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        p_q    <= p_d;
        ci_q   <= bus.ci;
        mode_q <= bus.mode;
        sgn_q  <= bus.sgn;
      end
    end
  end
  // stage 2 and accumulator: acc moves with the beat so back-to-back accumulates see every earlier beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      o_q    <= '0;
      ovf_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      if (s2_ld) s2_v_q <= s1_v_q;
      if (s1_mv) begin
        o_q   <= o_d;
        ovf_q <= ovf_d;
        if (mode_q[1]) acc_q <= o_d;
      end
    end
  end
endmodule

// File: tb/tb_ffra_mac_pipe.sv
// tb_ffra_mac_pipe: directed and model-backed checks of ffra_mac_pipe across three parameter sets
module tb_ffra_mac_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  int fails = 0;
  longint acc_m = 0, acc_s = 0, acc_l = 0;
  always #5 clk = ~clk;
  ffra_mac_pipe_if #(.A_W(8),  .B_W(8),  .O_W(16)) m_if ();
  ffra_mac_pipe_if #(.A_W(8),  .B_W(8),  .O_W(16)) w_if ();
  ffra_mac_pipe_if #(.A_W(4),  .B_W(4),  .O_W(8))  s_if ();
  ffra_mac_pipe_if #(.A_W(16), .B_W(16), .O_W(40)) l_if ();
  ffra_mac_pipe #(.A_W(8),  .B_W(8),  .O_W(16), .SAT(1'b1)) u_main  (.clk(clk), .rst_n(rst_n), .bus(m_if));
  ffra_mac_pipe #(.A_W(8),  .B_W(8),  .O_W(16), .SAT(1'b0)) u_wrap  (.clk(clk), .rst_n(rst_n), .bus(w_if));
  ffra_mac_pipe #(.A_W(4),  .B_W(4),  .O_W(8),  .SAT(1'b1)) u_small (.clk(clk), .rst_n(rst_n), .bus(s_if));
  ffra_mac_pipe #(.A_W(16), .B_W(16), .O_W(40), .SAT(1'b1)) u_large (.clk(clk), .rst_n(rst_n), .bus(l_if));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask
  function automatic longint ext(input longint v, input int w, input bit sg);
    longint x;
    x = v & ((longint'(1) << w) - 1);
    return (sg && x[w-1]) ? x - (longint'(1) << w) : x;
  endfunction
  // saturating reference: exact integer result, clamped to the O_W range of the beat's signedness
  function automatic void model(input longint ar, input longint br, input longint cr,
                                input int aw, input int bw, input int ow,
                                input logic [1:0] md, input bit sg,
                                inout longint acc, output longint o, output bit ov);
    longint p, cv, av, r, lo, hi;
    p  = ext(ar, aw, sg) * ext(br, bw, sg);
    cv = ext(cr, ow, sg);
    av = ext(acc, ow, sg);
    r  = (md == 2'b00) ? p + cv : (md == 2'b01) ? p - cv : (md == 2'b10) ? av + p : p + cv;
    lo = sg ? -(longint'(1) << (ow - 1)) : 0;
    hi = sg ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
    ov = (r > hi) || (r < lo);
    o  = (r > hi) ? hi : (r < lo) ? lo : r;
    o  = o & ((longint'(1) << ow) - 1);
    if (md[1]) acc = o;
  endfunction
  task automatic one_m(input logic [7:0] a, input logic [7:0] b, input logic [15:0] ci,
                       input logic [1:0] md, input logic sg,
                       input logic [15:0] eo, input logic eov, input string tag);
    @(negedge clk);
    m_if.in_valid = 1'b1; m_if.a = a; m_if.b = b; m_if.ci = ci; m_if.mode = md; m_if.sgn = sg;
    m_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_if.in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(m_if.out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(m_if.out_valid), 64'(1));
    chk({tag, "_o"}, 64'(m_if.o), 64'(eo));
    chk({tag, "_ovf"}, 64'(m_if.ovf), 64'(eov));
  endtask
  task automatic one_w(input logic [7:0] a, input logic [7:0] b, input logic [15:0] ci,
                       input logic [1:0] md, input logic sg,
                       input logic [15:0] eo, input logic eov, input string tag);
    @(negedge clk);
    w_if.in_valid = 1'b1; w_if.a = a; w_if.b = b; w_if.ci = ci; w_if.mode = md; w_if.sgn = sg;
    w_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(w_if.out_valid), 64'(1));
    chk({tag, "_o"}, 64'(w_if.o), 64'(eo));
    chk({tag, "_ovf"}, 64'(w_if.ovf), 64'(eov));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] acc_exp [4] = '{16'd16, 16'd17, 16'd18, 16'd19};
    longint eq_o[$], sq_o[$], lq_o[$];
    bit eq_v[$], sq_v[$], lq_v[$];
    longint mo;
    bit mv;
    int sent, got, infl, s_got, l_got;
    logic [63:0] ra, rb, rc;
    logic [1:0] rm;
    logic rs;
    m_if.in_valid = 0; m_if.a = '0; m_if.b = '0; m_if.ci = '0; m_if.mode = '0; m_if.sgn = 0; m_if.out_ready = 0;
    w_if.in_valid = 0; w_if.a = '0; w_if.b = '0; w_if.ci = '0; w_if.mode = '0; w_if.sgn = 0; w_if.out_ready = 0;
    s_if.in_valid = 0; s_if.a = '0; s_if.b = '0; s_if.ci = '0; s_if.mode = '0; s_if.sgn = 0; s_if.out_ready = 1;
    l_if.in_valid = 0; l_if.a = '0; l_if.b = '0; l_if.ci = '0; l_if.mode = '0; l_if.sgn = 0; l_if.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(m_if.out_valid), 64'(0));
    chk("rst_o", 64'(m_if.o), 64'(0));
    chk("rst_ovf", 64'(m_if.ovf), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(m_if.in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_beat", 64'(m_if.out_valid), 64'(0));
    one_m(8'hFF, 8'hFF, 16'h01FE, 2'b00, 1'b0, 16'hFFFF, 1'b0, "u_max_fit");
    one_m(8'hFF, 8'hFF, 16'h01FF, 2'b00, 1'b0, 16'hFFFF, 1'b1, "u_sat");
    one_m(8'hFD, 8'h04, 16'h0005, 2'b01, 1'b1, 16'hFFEF, 1'b0, "s_sub");
    one_m(8'h7F, 8'h81, 16'h8000, 2'b00, 1'b1, 16'h8000, 1'b1, "s_sat_lo");
    one_m(8'h00, 8'h00, 16'h0001, 2'b01, 1'b0, 16'h0000, 1'b1, "u_sat_neg");
    one_w(8'h80, 8'h80, 16'h8000, 2'b00, 1'b1, 16'hC000, 1'b0, "w_signed");
    one_w(8'hFF, 8'hFF, 16'h01FF, 2'b00, 1'b0, 16'h0000, 1'b1, "w_wrap");
    m_if.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) chk("acc_gap", 64'(m_if.out_valid), 64'(0));
      if (k >= 2) begin
        chk("acc_valid", 64'(m_if.out_valid), 64'(1));
        chk("acc_o", 64'(m_if.o), 64'(acc_exp[k-2]));
      end
      m_if.in_valid = (k < 4);
      m_if.sgn = 1'b0;
      m_if.mode = (k == 0) ? 2'b11 : 2'b10;
      m_if.a = (k == 0) ? 8'd2 : 8'd1;
      m_if.b = (k == 0) ? 8'd3 : 8'd1;
      m_if.ci = (k == 0) ? 16'd10 : 16'd0;
    end
    acc_m = 19;
    sent = 0; got = 0; infl = 0;
    for (int c = 0; c < 100 && got < 8; c++) begin
      @(negedge clk);
      m_if.out_ready = $urandom_range(0, 1);
      m_if.in_valid = (sent < 8);
      m_if.a = 8'($urandom); m_if.b = 8'($urandom); m_if.ci = 16'($urandom);
      m_if.mode = 2'($urandom); m_if.sgn = 1'($urandom);
      #1;
      chk("bp_in_ready", 64'(m_if.in_ready), 64'(!(infl == 2 && !m_if.out_ready)));
      if (m_if.out_valid && m_if.out_ready) begin
        if (eq_o.size() == 0) chk("bp_extra_beat", 64'(1), 64'(0));
        else begin
          chk("bp_o", 64'(m_if.o), 64'(eq_o.pop_front()));
          chk("bp_ovf", 64'(m_if.ovf), 64'(eq_v.pop_front()));
        end
        got++; infl--;
      end
      if (m_if.in_valid && m_if.in_ready) begin
        model(longint'(m_if.a), longint'(m_if.b), longint'(m_if.ci), 8, 8, 16, m_if.mode, m_if.sgn, acc_m, mo, mv);
        eq_o.push_back(mo); eq_v.push_back(mv);
        sent++; infl++;
      end
    end
    chk("bp_beats", 64'(got), 64'(8));
    @(negedge clk);
    m_if.in_valid = 1'b1; m_if.out_ready = 1'b0;
    m_if.a = 8'd1; m_if.b = 8'd1; m_if.ci = 16'd0; m_if.mode = 2'b00; m_if.sgn = 1'b0;
    @(negedge clk);
    m_if.a = 8'd2;
    @(negedge clk);
    m_if.in_valid = 1'b0;
    chk("mid_full", 64'(m_if.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_if.out_valid), 64'(0));
    chk("mid_rst_o", 64'(m_if.o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = 0;
    #1;
    chk("mid_rst_release", 64'(m_if.out_valid), 64'(0));
    one_m(8'd1, 8'd1, 16'd0, 2'b10, 1'b0, 16'd1, 1'b0, "mid_acc");
    m_if.out_ready = 1'b1;
    s_got = 0; l_got = 0;
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      if (s_if.out_valid) begin
        if (sq_o.size() == 0) chk("sw_s_extra", 64'(1), 64'(0));
        else begin
          chk("sw_s_o", 64'(s_if.o), 64'(sq_o.pop_front()));
          chk("sw_s_ovf", 64'(s_if.ovf), 64'(sq_v.pop_front()));
        end
        s_got++;
      end
      if (l_if.out_valid) begin
        if (lq_o.size() == 0) chk("sw_l_extra", 64'(1), 64'(0));
        else begin
          chk("sw_l_o", 64'(l_if.o), 64'(lq_o.pop_front()));
          chk("sw_l_ovf", 64'(l_if.ovf), 64'(lq_v.pop_front()));
        end
        l_got++;
      end
      s_if.in_valid = (c < 40);
      l_if.in_valid = (c < 40);
      if (c < 40) begin
        ra = 64'($urandom_range(0, 15)); rb = 64'($urandom_range(0, 15)); rc = 64'($urandom_range(0, 255));
        rm = 2'($urandom); rs = 1'($urandom);
        s_if.a = ra[3:0]; s_if.b = rb[3:0]; s_if.ci = rc[7:0]; s_if.mode = rm; s_if.sgn = rs;
        model(longint'(ra), longint'(rb), longint'(rc), 4, 4, 8, rm, rs, acc_s, mo, mv);
        sq_o.push_back(mo); sq_v.push_back(mv);
        ra = 64'($urandom_range(0, 65535)); rb = 64'($urandom_range(0, 65535));
        rc = {24'd0, 8'($urandom), 32'($urandom)};
        rm = 2'($urandom); rs = 1'($urandom);
        l_if.a = ra[15:0]; l_if.b = rb[15:0]; l_if.ci = rc[39:0]; l_if.mode = rm; l_if.sgn = rs;
        model(longint'(ra), longint'(rb), longint'(rc), 16, 16, 40, rm, rs, acc_l, mo, mv);
        lq_o.push_back(mo); lq_v.push_back(mv);
      end
    end
    chk("sw_s_count", 64'(s_got), 64'(40));
    chk("sw_l_count", 64'(l_got), 64'(40));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
